// File: rtl/hdb3_pkg.sv
// Shared definitions for the HDB3 transmit path: framing FSM state encoding
// and default line-rate / sync-word settings.
package hdb3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam int unsigned CLK_DIV_DEF   = 8;
  localparam logic [7:0]  SYNC_WORD_DEF = 8'hE4;
  localparam int unsigned FRAME_CNT_W   = 16;
  localparam int unsigned IDX_W         = 32;

endpackage

// File: rtl/tx_frame_ctrl_if.sv
// Control, bit-source and line-side signals of the transmit framing controller.
//   start/stop/cont : framing control (bench/host -> controller)
//   src_req/src_data: payload bit request / returned bit
//   bit_out/bit_stb/in_sync: line bit, update strobe, sync-bit flag
//   busy/frame_done/frame_cnt: framing status
interface tx_frame_ctrl_if;
  import hdb3_pkg::*;

  logic                   start;
  logic                   stop;
  logic                   cont;
  logic                   src_req;
  logic                   src_data;
  logic                   bit_out;
  logic                   bit_stb;
  logic                   in_sync;
  logic                   busy;
  logic                   frame_done;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  // Host / bit source side
  modport master (
    output start, stop, cont, src_data,
    input  src_req, bit_out, bit_stb, in_sync, busy, frame_done, frame_cnt
  );

  // Framing controller side
  modport slave (
    input  start, stop, cont, src_data,
    output src_req, bit_out, bit_stb, in_sync, busy, frame_done, frame_cnt
  );

endinterface

// File: rtl/bit_rate_div.sv
// Line bit-period divider: counts 0..CLK_DIV-1 while enabled.
//   clk, rst_n : clock, async active-low reset
//   clr        : force count to 0 (takes priority over en)
//   en         : count enable
//   tick       : count is at CLK_DIV-1 (last clock of a bit period)
//   pre_tick   : count is at CLK_DIV-2 (one clock before tick)
module bit_rate_div #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  assign tick     = en && (div_cnt_q == CNT_W'(CLK_DIV - 1));
  assign pre_tick = en && (div_cnt_q == CNT_W'(CLK_DIV - 2));

  // Next count
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Transmit framing controller: emits sync word, payload (pulled bit by bit
// from the source) and a zero gap, one bit per CLK_DIV clocks, in one-shot
// or continuous mode.
//   clk, rst_n : clock, async active-low reset
//   bus        : control, source and line signals (tx_frame_ctrl_if.slave)
// A bit period ends on a divider tick; the bit belonging to that period is
// loaded into bit_out on that tick, so the frame ends on the tick that loads
// its final bit.
module tx_frame_ctrl
  import hdb3_pkg::*;
#(
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter logic [31:0] SYNC_WORD   = 32'(SYNC_WORD_DEF),
  parameter int unsigned SYNC_LEN    = 8,
  parameter int unsigned PAYLOAD_LEN = 16,
  parameter int unsigned GAP_LEN     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  tx_frame_ctrl_if.slave bus
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   bit_out_q, bit_out_d;
  logic                   bit_stb_q, bit_stb_d;
  logic                   in_sync_q, in_sync_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   stop_pend_q, stop_pend_d;

  logic                   tick;
  logic                   pre_tick;
  logic                   div_clr_c;
  logic                   frame_end_c;
  logic                   src_req_c;
  logic [4:0]             sync_sel_c;

  bit_rate_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (div_clr_c),
    .en       (busy_q),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // Sync word is sent MSB first
  assign sync_sel_c = 5'(SYNC_LEN - 1) - idx_q[4:0];

  // Request lands one clock before the tick that captures src_data
  assign src_req_c = pre_tick && (state_q == ST_PAYLOAD);

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bit_out_d    = bit_out_q;
    bit_stb_d    = 1'b0;
    in_sync_d    = in_sync_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    stop_pend_d  = stop_pend_q;
    div_clr_c    = 1'b0;
    frame_end_c  = 1'b0;

    if (busy_q && bus.stop) begin
      stop_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_SYNC;
          idx_d       = '0;
          busy_d      = 1'b1;
          div_clr_c   = 1'b1;
          stop_pend_d = bus.stop;
        end
      end
      ST_SYNC: begin
        if (tick) begin
          bit_out_d = SYNC_WORD[sync_sel_c];
          in_sync_d = 1'b1;
          bit_stb_d = 1'b1;
          if (idx_q == IDX_W'(SYNC_LEN - 1)) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        if (tick) begin
          bit_out_d = bus.src_data;
          in_sync_d = 1'b0;
          bit_stb_d = 1'b1;
          if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
            idx_d = '0;
            if (GAP_LEN == 0) begin
              frame_end_c = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          bit_out_d = 1'b0;
          in_sync_d = 1'b0;
          bit_stb_d = 1'b1;
          if (idx_q == IDX_W'(GAP_LEN - 1)) begin
            frame_end_c = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame boundary: count it, then either chain the next frame or go idle.
    // A stop arriving on this very clock still prevents the next frame.
    if (frame_end_c) begin
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
      idx_d        = '0;
      if (bus.cont && !stop_pend_d) begin
        state_d = ST_SYNC;
      end else begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      bit_out_q    <= 1'b0;
      bit_stb_q    <= 1'b0;
      in_sync_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bit_out_q    <= bit_out_d;
      bit_stb_q    <= bit_stb_d;
      in_sync_q    <= in_sync_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  assign bus.src_req    = src_req_c;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_stb    = bit_stb_q;
  assign bus.in_sync    = in_sync_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl: default instance (8 clk/bit,
// 28-bit frame) plus a short-frame instance (2 clk/bit, 1 payload, no gap).
module tb_tx_frame_ctrl;
  import hdb3_pkg::*;

  typedef struct {
    logic exp_bit;
    logic exp_sync;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_frame_ctrl_if b1 ();
  tx_frame_ctrl_if b2 ();

  tx_frame_ctrl dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  tx_frame_ctrl #(
    .CLK_DIV     (2),
    .SYNC_WORD   (32'h0000_00E4),
    .SYNC_LEN    (8),
    .PAYLOAD_LEN (1),
    .GAP_LEN     (0)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  vec_t tbl [28];
  int   e0, e2;

  // Monitor state for dut1
  int   stb_n, last_stb, space_err, done_n, last_done, req_n, src_idx;
  // Monitor state for dut2
  int   stb2_n, last_stb2, space2_err, done2_n, last_done2, req2_n, last_req2;
  int   req_err2, pay_err2;
  logic s2_next, last_src2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // dut1 monitor + bit source returning 1,0,1,0...
  always @(negedge clk) begin
    if (b1.bit_stb) begin
      if (stb_n > 0 && (cyc - last_stb) != 8) space_err++;
      last_stb = cyc;
      stb_n++;
    end
    if (b1.frame_done) begin
      done_n++;
      last_done = cyc;
    end
    if (b1.src_req) begin
      b1.src_data = (src_idx % 2 == 0) ? 1'b1 : 1'b0;
      src_idx++;
      req_n++;
    end
  end

  // dut2 monitor + toggling bit source
  always @(negedge clk) begin
    if (b2.bit_stb) begin
      if (stb2_n > 0 && (cyc - last_stb2) != 2) space2_err++;
      if (!b2.in_sync) begin
        if (cyc - last_req2 != 2) req_err2++;
        if (b2.bit_out !== last_src2) pay_err2++;
      end
      last_stb2 = cyc;
      stb2_n++;
    end
    if (b2.frame_done) begin
      done2_n++;
      last_done2 = cyc;
    end
    if (b2.src_req) begin
      b2.src_data = s2_next;
      last_src2   = s2_next;
      s2_next     = ~s2_next;
      last_req2   = cyc;
      req2_n++;
    end
  end

  task automatic clear_mon();
    stb_n = 0; last_stb = 0; space_err = 0; done_n = 0; last_done = 0; req_n = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start1(input logic c, input logic s);
    @(negedge clk);
    b1.start = 1'b1;
    b1.stop  = s;
    b1.cont  = c;
    src_idx  = 0;
    @(negedge clk);
    e0 = cyc;
    b1.start = 1'b0;
    b1.stop  = 1'b0;
  endtask

  task automatic wait_stb1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.bit_stb) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle1(input int lim, input string nm);
    for (int i = 0; i < lim && b1.busy; i++) @(negedge clk);
    check(nm, 32'(b1.busy), 32'd0);
  endtask

  // Walk one full frame against the table: value, sync flag and strobe time
  task automatic check_frame1(input string tag);
    bit ok;
    for (int k = 0; k < 28; k++) begin
      wait_stb1(ok);
      if (!ok) begin
        check($sformatf("%s stb%0d_timeout", tag, k), 32'd0, 32'd1);
        return;
      end
      check($sformatf("%s bit%0d", tag, k), 32'(b1.bit_out), 32'(tbl[k].exp_bit));
      check($sformatf("%s sync%0d", tag, k), 32'(b1.in_sync), 32'(tbl[k].exp_sync));
      check($sformatf("%s time%0d", tag, k), 32'(cyc - e0), 32'(8 * (k + 1)));
    end
  endtask

  initial begin
    logic [27:0] pat;
    pat = 28'b1110_0100_1010_1010_1010_1010_0000;
    for (int k = 0; k < 28; k++) begin
      tbl[k].exp_bit  = pat[27 - k];
      tbl[k].exp_sync = (k < 8);
    end

    b1.start = 0; b1.stop = 0; b1.cont = 0; b1.src_data = 0;
    b2.start = 0; b2.stop = 0; b2.cont = 0; b2.src_data = 0;
    s2_next = 1'b1; last_src2 = 1'b0;
    stb2_n = 0; last_stb2 = 0; space2_err = 0; done2_n = 0; last_done2 = 0;
    req2_n = 0; last_req2 = 0; req_err2 = 0; pay_err2 = 0;
    src_idx = 0;
    clear_mon();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst busy", 32'(b1.busy), 0);
    check("rst bit_out", 32'(b1.bit_out), 0);
    check("rst bit_stb", 32'(b1.bit_stb), 0);
    check("rst src_req", 32'(b1.src_req), 0);
    check("rst in_sync", 32'(b1.in_sync), 0);
    check("rst frame_done", 32'(b1.frame_done), 0);
    check("rst frame_cnt", 32'(b1.frame_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single one-shot frame
    clear_mon();
    start1(1'b0, 1'b0);
    check("single busy_after_start", 32'(b1.busy), 1);
    check_frame1("single");
    @(negedge clk);
    check("single done_n", 32'(done_n), 1);
    check("single done_time", 32'(last_done - e0), 224);
    check("single frame_cnt", 32'(b1.frame_cnt), 1);
    check("single busy_end", 32'(b1.busy), 0);
    check("single req_n", 32'(req_n), 16);
    repeat (20) @(negedge clk);
    check("single idle_bit_out", 32'(b1.bit_out), 0);
    check("single idle_stb_n", 32'(stb_n), 28);

    // Continuous, stop during third frame's payload
    do_reset();
    clear_mon();
    start1(1'b1, 1'b0);
    while (cyc < e0 + 548) @(negedge clk);
    b1.stop = 1'b1;
    @(negedge clk);
    b1.stop = 1'b0;
    wait_idle1(400, "cont idle_timeout");
    @(negedge clk);
    check("cont done_n", 32'(done_n), 3);
    check("cont last_done", 32'(last_done - e0), 672);
    check("cont frame_cnt", 32'(b1.frame_cnt), 3);
    check("cont stb_n", 32'(stb_n), 84);
    check("cont spacing", 32'(space_err), 0);
    check("cont req_n", 32'(req_n), 48);
    repeat (40) @(negedge clk);
    check("cont stays_idle", 32'(stb_n), 84);

    // Reset mid-payload (bit 5), then a clean frame
    clear_mon();
    start1(1'b0, 1'b0);
    while (cyc < e0 + 110) @(negedge clk);
    check("midrst bit_before", 32'(b1.bit_out), 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(b1.busy), 0);
    check("midrst bit_out", 32'(b1.bit_out), 0);
    check("midrst bit_stb", 32'(b1.bit_stb), 0);
    check("midrst src_req", 32'(b1.src_req), 0);
    check("midrst in_sync", 32'(b1.in_sync), 0);
    check("midrst frame_cnt", 32'(b1.frame_cnt), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst no_done", 32'(done_n), 0);
    clear_mon();
    start1(1'b0, 1'b0);
    check_frame1("after_rst");
    @(negedge clk);
    check("after_rst done_n", 32'(done_n), 1);
    check("after_rst frame_cnt", 32'(b1.frame_cnt), 1);

    // start and stop together in IDLE with cont=1: exactly one frame
    do_reset();
    clear_mon();
    start1(1'b1, 1'b1);
    wait_idle1(500, "startstop idle_timeout");
    @(negedge clk);
    check("startstop done_time", 32'(last_done - e0), 224);
    repeat (240) @(negedge clk);
    check("startstop done_n", 32'(done_n), 1);
    check("startstop frame_cnt", 32'(b1.frame_cnt), 1);
    check("startstop stb_n", 32'(stb_n), 28);

    // stop while idle and start while busy have no effect
    do_reset();
    clear_mon();
    @(negedge clk);
    b1.stop = 1'b1;
    @(negedge clk);
    b1.stop = 1'b0;
    check("ign idle_stop_busy", 32'(b1.busy), 0);
    start1(1'b1, 1'b0);
    while (cyc < e0 + 100) @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    while (cyc < e0 + 300) @(negedge clk);
    b1.stop = 1'b1;
    @(negedge clk);
    b1.stop = 1'b0;
    wait_idle1(400, "ign idle_timeout");
    @(negedge clk);
    check("ign done_n", 32'(done_n), 2);
    check("ign last_done", 32'(last_done - e0), 448);
    check("ign frame_cnt", 32'(b1.frame_cnt), 2);
    check("ign stb_n", 32'(stb_n), 56);
    check("ign spacing", 32'(space_err), 0);

    // Short-frame instance: CLK_DIV=2, PAYLOAD_LEN=1, GAP_LEN=0
    @(negedge clk);
    b2.start = 1'b1;
    b2.cont  = 1'b1;
    @(negedge clk);
    e2 = cyc;
    b2.start = 1'b0;
    while (cyc < e2 + 37) @(negedge clk);
    check("short done_n2", 32'(done2_n), 2);
    check("short period", 32'(last_done2 - e2), 36);
    check("short frame_cnt2", 32'(b2.frame_cnt), 2);
    check("short req_n2", 32'(req2_n), 2);
    while (cyc < e2 + 40) @(negedge clk);
    force dut2.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut2.frame_cnt_q;
    @(negedge clk);
    check("short preload", 32'(b2.frame_cnt), 32'hFFFF);
    while (cyc < e2 + 54) @(negedge clk);
    check("short wrap", 32'(b2.frame_cnt), 0);
    b2.stop = 1'b1;
    @(negedge clk);
    b2.stop = 1'b0;
    for (int i = 0; i < 100 && b2.busy; i++) @(negedge clk);
    check("short idle", 32'(b2.busy), 0);
    @(negedge clk);
    check("short last_done2", 32'(last_done2 - e2), 72);
    check("short final_cnt", 32'(b2.frame_cnt), 1);
    check("short req_total", 32'(req2_n), 4);
    check("short req_to_stb", 32'(req_err2), 0);
    check("short payload_val", 32'(pay_err2), 0);
    check("short spacing", 32'(space2_err), 0);
    check("short stb_total", 32'(stb2_n), 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
